// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding, instruction constants, and PC helpers.
// Imported by the fetch stage and anything that needs to read its state or reset values.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: shown to the decoder before the first real fetch.
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;

    // The instruction word presented to the decoder, plus the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_slot_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem request, one-cycle o_we pulse per delivered word.
// Latency: request cycle N, response N+L, o_instr/o_we and next request in N+L+1.
// Backpressure: i_stall parks a captured word in S_HOLD; redirect drains any in-flight response.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_valid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic            o_we,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inc;
    fetch_slot_t     out_q, out_d;
    logic            we_q, we_d;

    assign pc_inc = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            out_q.instr <= NOP_INSTR;
            out_q.pc    <= RESET_PC;
            we_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        we_d    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (i_imem_valid) begin
                    out_d.instr = i_imem_rdata;
                    out_d.pc    = pc_q;
                    if (!i_stall) begin
                        we_d    = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    we_d    = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_imem_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above; a response landing this cycle belongs to the
        // old path, so the captured slot is left untouched and no pulse is issued.
        if (i_redirect) begin
            pc_d  = word_align(i_target);
            we_d  = 1'b0;
            out_d = out_q;
            case (state_q)
                S_REQ:           state_d = S_DRAIN;
                S_WAIT, S_DRAIN: state_d = i_imem_valid ? S_REQ : S_DRAIN;
                default:         state_d = S_REQ;
            endcase
        end
    end

    assign o_imem_req  = (state_q == S_REQ);
    assign o_imem_addr = pc_q;
    assign o_instr     = out_q.instr;
    assign o_pc        = out_q.pc;
    assign o_pc_plus4  = out_q.pc + XLEN'(4);
    assign o_we        = we_q;

endmodule
